// File: rtl/jtag_pkg.sv
// TAP state encodings and instruction constants shared by the TAP controller and its decode logic.
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR      = 4'hF,
        RTI      = 4'hC,
        SEL_DR   = 4'h7,
        CAP_DR   = 4'h6,
        SH_DR    = 4'h2,
        EX1_DR   = 4'h1,
        PAUSE_DR = 4'h3,
        EX2_DR   = 4'h0,
        UPD_DR   = 4'h5,
        SEL_IR   = 4'h4,
        CAP_IR   = 4'hE,
        SH_IR    = 4'hA,
        EX1_IR   = 4'h9,
        PAUSE_IR = 4'hB,
        EX2_IR   = 4'h8,
        UPD_IR   = 4'hD
    } tap_state_e;

    // Low bits loaded into the IR shift register in Capture-IR; upper bits are zero.
    localparam logic [1:0] IR_CAPTURE = 2'b01;

    function automatic logic [31:0] bypass_opcode(input int width);
        return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller: state advances on posedge tck from tms, trst forces Test-Logic-Reset.
// Decode outputs are combinational from the state register.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic tck_i,
    input  logic trst_i,
    input  logic tms_i,
    output logic tlr_o,
    output logic cap_dr_o,
    output logic sh_dr_o,
    output logic upd_dr_o,
    output logic cap_ir_o,
    output logic sh_ir_o,
    output logic upd_ir_o
);

    tap_state_e state_q, state_d;

    always_ff @(posedge tck_i or negedge trst_i) begin
        if (!trst_i) state_q <= TLR;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:      state_d = tms_i ? TLR      : RTI;
            RTI:      state_d = tms_i ? SEL_DR   : RTI;
            SEL_DR:   state_d = tms_i ? SEL_IR   : CAP_DR;
            CAP_DR:   state_d = tms_i ? EX1_DR   : SH_DR;
            SH_DR:    state_d = tms_i ? EX1_DR   : SH_DR;
            EX1_DR:   state_d = tms_i ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_d = tms_i ? EX2_DR   : PAUSE_DR;
            EX2_DR:   state_d = tms_i ? UPD_DR   : SH_DR;
            UPD_DR:   state_d = tms_i ? SEL_DR   : RTI;
            SEL_IR:   state_d = tms_i ? TLR      : CAP_IR;
            CAP_IR:   state_d = tms_i ? EX1_IR   : SH_IR;
            SH_IR:    state_d = tms_i ? EX1_IR   : SH_IR;
            EX1_IR:   state_d = tms_i ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_d = tms_i ? EX2_IR   : PAUSE_IR;
            EX2_IR:   state_d = tms_i ? UPD_IR   : SH_IR;
            UPD_IR:   state_d = tms_i ? SEL_DR   : RTI;
            default:  state_d = TLR;
        endcase
    end

    assign tlr_o    = (state_q == TLR);
    assign cap_dr_o = (state_q == CAP_DR);
    assign sh_dr_o  = (state_q == SH_DR);
    assign upd_dr_o = (state_q == UPD_DR);
    assign cap_ir_o = (state_q == CAP_IR);
    assign sh_ir_o  = (state_q == SH_IR);
    assign upd_ir_o = (state_q == UPD_IR);

endmodule

// File: rtl/jtag_tap_ir.sv
// JTAG TAP with instruction register, BYPASS/IDCODE DRs and user-channel decode.
// Shift registers move on posedge tck; tdo, enables, strobes and instr change on negedge tck.
module jtag_tap_ir
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH     = 5,
    parameter logic [31:0] IDCODE_VAL   = 32'h1000_0001,
    parameter int          IDCODE_INSTR = 1,
    parameter int          USER_BASE    = 16,
    parameter int          NUM_USER     = 4
) (
    input  logic                tck,
    input  logic                trst,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_en,
    output logic [IR_WIDTH-1:0] instr,
    output logic [NUM_USER-1:0] user_sel,
    input  logic [NUM_USER-1:0] user_tdo,
    output logic                capture_dr,
    output logic                shift_dr,
    output logic                update_dr,
    output logic                tlr
);

    localparam logic [IR_WIDTH-1:0] IR_CAP_VAL = IR_WIDTH'(IR_CAPTURE);
    localparam logic [IR_WIDTH-1:0] BYPASS_OP  = IR_WIDTH'(bypass_opcode(IR_WIDTH));
    localparam logic [IR_WIDTH-1:0] IDCODE_OP  = IR_WIDTH'(IDCODE_INSTR);

    logic tlr_s, cap_dr_s, sh_dr_s, upd_dr_s, cap_ir_s, sh_ir_s, upd_ir_s;

    jtag_tap_fsm u_fsm (
        .tck_i    (tck),
        .trst_i   (trst),
        .tms_i    (tms),
        .tlr_o    (tlr_s),
        .cap_dr_o (cap_dr_s),
        .sh_dr_o  (sh_dr_s),
        .upd_dr_o (upd_dr_s),
        .cap_ir_o (cap_ir_s),
        .sh_ir_o  (sh_ir_s),
        .upd_ir_o (upd_ir_s)
    );

    logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
    logic [IR_WIDTH-1:0] instr_q, instr_d;
    logic                bypass_q, bypass_d;
    logic [31:0]         idcode_q, idcode_d;
    logic                tdo_q, tdo_d;
    logic                tdo_en_q, capture_q, shift_q;

    logic                sel_bypass_op, sel_idcode, sel_user, sel_bypass;
    logic [NUM_USER-1:0] user_sel_c;
    logic                dr_lsb;

    // All-ones always wins so BYPASS can never be shadowed by a user range that overlaps it.
    always_comb begin
        sel_bypass_op = (instr_q == BYPASS_OP);
        sel_idcode    = !sel_bypass_op && (instr_q == IDCODE_OP);
        user_sel_c    = '0;
        for (int k = 0; k < NUM_USER; k++) begin
            user_sel_c[k] = !sel_bypass_op && !sel_idcode && (int'(instr_q) == USER_BASE + k);
        end
        sel_user   = |user_sel_c;
        sel_bypass = !sel_idcode && !sel_user;
    end

    always_comb begin
        ir_sr_d = ir_sr_q;
        if (cap_ir_s)     ir_sr_d = IR_CAP_VAL;
        else if (sh_ir_s) ir_sr_d = {tdi, ir_sr_q[IR_WIDTH-1:1]};

        bypass_d = bypass_q;
        if (sel_bypass && cap_dr_s)     bypass_d = 1'b0;
        else if (sel_bypass && sh_dr_s) bypass_d = tdi;

        idcode_d = idcode_q;
        if (sel_idcode && cap_dr_s)     idcode_d = IDCODE_VAL;
        else if (sel_idcode && sh_dr_s) idcode_d = {tdi, idcode_q[31:1]};
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            ir_sr_q  <= IR_CAP_VAL;
            bypass_q <= 1'b0;
            idcode_q <= IDCODE_VAL;
        end else begin
            ir_sr_q  <= ir_sr_d;
            bypass_q <= bypass_d;
            idcode_q <= idcode_d;
        end
    end

    always_comb begin
        if (sel_idcode)    dr_lsb = idcode_q[0];
        else if (sel_user) dr_lsb = |(user_tdo & user_sel_c);
        else               dr_lsb = bypass_q;

        tdo_d = tdo_q;
        if (sh_ir_s)      tdo_d = ir_sr_q[0];
        else if (sh_dr_s) tdo_d = dr_lsb;

        instr_d = instr_q;
        if (tlr_s)         instr_d = IDCODE_OP;
        else if (upd_ir_s) instr_d = ir_sr_q;
    end

    // Negedge launch gives external DRs and the pin a full half cycle of setup before the shifting posedge.
    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            tdo_q     <= 1'b0;
            tdo_en_q  <= 1'b0;
            capture_q <= 1'b0;
            shift_q   <= 1'b0;
            instr_q   <= IDCODE_OP;
        end else begin
            tdo_q     <= tdo_d;
            tdo_en_q  <= sh_ir_s | sh_dr_s;
            capture_q <= cap_dr_s;
            shift_q   <= sh_dr_s;
            instr_q   <= instr_d;
        end
    end

    assign tdo        = tdo_q;
    assign tdo_en     = tdo_en_q;
    assign instr      = instr_q;
    assign user_sel   = user_sel_c;
    assign capture_dr = capture_q;
    assign shift_dr   = shift_q;
    assign update_dr  = upd_dr_s & ~tck;
    assign tlr        = tlr_s;

endmodule

// File: tb/tb_jtag_tap_ir.sv
// Directed bench for jtag_tap_ir: reset, IDCODE/BYPASS/user scans, IR capture, trst abort, pause-resume.
module tb_jtag_tap_ir;

    logic       tck = 1'b0;
    logic       trst, tms, tdi;
    logic       tdo, tdo_en;
    logic [4:0] instr;
    logic [3:0] user_sel, user_tdo;
    logic       capture_dr, shift_dr, update_dr, tlr;

    int total = 0;
    int bad   = 0;
    int upd_cnt = 0;
    int upd_base;
    logic [31:0] dout;
    logic [4:0]  irout;

    jtag_tap_ir dut (
        .tck        (tck),
        .trst       (trst),
        .tms        (tms),
        .tdi        (tdi),
        .tdo        (tdo),
        .tdo_en     (tdo_en),
        .instr      (instr),
        .user_sel   (user_sel),
        .user_tdo   (user_tdo),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .tlr        (tlr)
    );

    always #10 tck = ~tck;

    always @(posedge update_dr) upd_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change just after negedge; outputs are sampled 1 time unit after the following negedge.
    task automatic clk(input logic m, input logic d);
        tms = m;
        tdi = d;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    task automatic load_ir(input logic [4:0] v, output logic [4:0] out);
        out = '0;
        clk(1'b1, 1'b0);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            out[i] = tdo;
            clk(i == 4, v[i]);
        end
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
    endtask

    task automatic dr_scan(input int n, input logic [31:0] din, output logic [31:0] dq);
        dq = '0;
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        check("capture_dr_in_cap", {31'b0, capture_dr}, 32'd1);
        clk(1'b0, 1'b0);
        check("shift_dr_in_shift", {31'b0, shift_dr}, 32'd1);
        check("tdo_en_in_shift", {31'b0, tdo_en}, 32'd1);
        for (int i = 0; i < n; i++) begin
            dq[i] = tdo;
            clk(i == n - 1, din[i]);
        end
        check("tdo_en_after_shift", {31'b0, tdo_en}, 32'd0);
        clk(1'b1, 1'b0);
        check("update_dr_in_upd", {31'b0, update_dr}, 32'd1);
        clk(1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        trst = 1'b0;
        tms = 1'b1;
        tdi = 1'b0;
        user_tdo = 4'b0000;
        repeat (2) @(negedge tck);
        #1;
        check("rst_tlr", {31'b0, tlr}, 32'd1);
        check("rst_instr", {27'b0, instr}, 32'd1);
        check("rst_tdo", {31'b0, tdo}, 32'd0);
        check("rst_tdo_en", {31'b0, tdo_en}, 32'd0);
        check("rst_user_sel", {28'b0, user_sel}, 32'd0);
        check("rst_strobes", {29'b0, capture_dr, shift_dr, update_dr}, 32'd0);
        trst = 1'b1;

        repeat (5) clk(1'b1, 1'b0);
        check("idle_tlr", {31'b0, tlr}, 32'd1);
        check("idle_instr", {27'b0, instr}, 32'd1);
        check("idle_tdo_en", {31'b0, tdo_en}, 32'd0);
        clk(1'b0, 1'b0);
        check("rti_tlr_low", {31'b0, tlr}, 32'd0);

        dr_scan(32, 32'h0, dout);
        check("idcode_stream", dout, 32'h1000_0001);

        load_ir(5'h1F, irout);
        check("bypass_instr", {27'b0, instr}, 32'h1F);
        check("ir_capture_1f", {27'b0, irout}, 32'h01);
        check("bypass_user_sel", {28'b0, user_sel}, 32'd0);
        dr_scan(4, 32'hD, dout);
        check("bypass_delay", dout, 32'hA);

        load_ir(5'h12, irout);
        check("user_instr", {27'b0, instr}, 32'h12);
        check("user_sel_ch2", {28'b0, user_sel}, 32'h4);
        user_tdo = 4'b0100;
        upd_base = upd_cnt;
        dr_scan(4, 32'h0, dout);
        check("user_tdo_ones", dout, 32'hF);
        check("user_update_pulses", upd_cnt - upd_base, 32'd1);
        user_tdo = 4'b1011;
        dr_scan(4, 32'hF, dout);
        check("user_tdo_zeros", dout, 32'h0);
        user_tdo = 4'b0000;

        load_ir(5'h07, irout);
        check("undef_instr", {27'b0, instr}, 32'h07);
        check("undef_user_sel", {28'b0, user_sel}, 32'd0);
        check("ir_first_two", {30'b0, irout[1:0]}, 32'h1);
        dr_scan(4, 32'h6, dout);
        check("undef_bypass", dout, 32'hC);

        clk(1'b1, 1'b0);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        repeat (3) clk(1'b0, 1'b1);
        upd_base = upd_cnt;
        trst = 1'b0;
        #1;
        check("abort_tlr", {31'b0, tlr}, 32'd1);
        check("abort_instr", {27'b0, instr}, 32'd1);
        check("abort_tdo_en", {31'b0, tdo_en}, 32'd0);
        #4;
        trst = 1'b1;
        clk(1'b1, 1'b0);
        clk(1'b1, 1'b0);
        check("abort_no_update", upd_cnt - upd_base, 32'd0);
        check("abort_instr_held", {27'b0, instr}, 32'd1);

        clk(1'b0, 1'b0);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        check("pause_first_bit", {31'b0, tdo}, 32'd1);
        repeat (8) clk(1'b0, 1'b0);
        clk(1'b1, 1'b0);
        check("pause_ex1_tdo_en", {31'b0, tdo_en}, 32'd0);
        clk(1'b0, 1'b0);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        dout = '0;
        for (int i = 0; i < 23; i++) begin
            dout[i] = tdo;
            clk(i == 22, 1'b0);
        end
        check("pause_resume_bits", dout, 32'h0008_0000);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
